// File: rtl/mmo_regs_pkg.sv
// rtl/mmo_regs_pkg.sv - shared constants, monitor state type and byte-mask helper
package mmo_regs_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [ADDR_W-1:0] REG_STATUS = 5'd29;
  localparam logic [ADDR_W-1:0] REG_H2F_DB = 5'd30;
  localparam logic [ADDR_W-1:0] REG_F2H_DB = 5'd31;

  localparam int ST_STARVE_BIT = 31;
  localparam int ST_H2F_BIT    = 30;
  localparam int ST_F2H_BIT    = 29;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mon_state_e;

  // Expand byte enables into a per-bit write mask.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mmo_wait_monitor.sv
// rtl/mmo_wait_monitor.sv - fabric wait-time tracker with longest-wait and sticky starve flag
module mmo_wait_monitor
  import mmo_regs_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int WAIT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              gnt,
  input  logic              clr,
  output logic [WAIT_W-1:0] max_wait,
  output logic              starve
);

  mon_state_e        state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              upd_max;
  logic              starve_set;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Wait tracking: the first denied cycle counts as 1; leaving WAIT (grant or
  // an illegal request drop) folds the count into the running maximum.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    upd_max   = 1'b0;
    case (state)
      IDLE: begin
        if (req && !gnt) begin
          state_nxt = WAIT;
          cnt_nxt   = {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      WAIT: begin
        if (gnt || !req) begin
          state_nxt = IDLE;
          upd_max   = 1'b1;
        end else if (cnt != {WAIT_W{1'b1}}) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    starve_set = (state_nxt == WAIT) && (int'(cnt_nxt) >= STARVE_LIMIT);
  end

  // Status-visible results; an HPS clear beats a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_wait <= '0;
      starve   <= 1'b0;
    end else if (clr) begin
      max_wait <= '0;
      starve   <= 1'b0;
    end else begin
      if (upd_max && (cnt > max_wait)) max_wait <= cnt;
      if (starve_set) starve <= 1'b1;
    end
  end

endmodule

// File: rtl/mmo_shared_regs_arb.sv
// rtl/mmo_shared_regs_arb.sv - HPS/fabric shared register bank with doorbells and starvation status
module mmo_shared_regs_arb
  import mmo_regs_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int WAIT_W       = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] mmo_address,
  input  logic [DATA_W-1:0] mmo_writedata,
  input  logic [BE_W-1:0]   mmo_byteenable,
  input  logic              mmo_read,
  input  logic              mmo_write,
  output logic [DATA_W-1:0] mmo_readdata,
  input  logic              usr_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  input  logic [BE_W-1:0]   usr_be,
  output logic              usr_gnt,
  output logic              usr_rvalid,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              h2f_irq,
  output logic              f2h_irq
);

  logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] status;
  logic [WAIT_W-1:0] max_wait;
  logic              starve;
  logic              status_clr;
  logic              hps_wr, fab_wr, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_md, wr_mask, wr_cur, wr_val;
  logic [DATA_W-1:0] mmo_rd_val, usr_rd_val;
  logic              h2f_nxt, f2h_nxt;

  // HPS has no waitrequest, so any HPS strobe blocks the fabric this cycle.
  assign usr_gnt    = usr_req & ~(mmo_read | mmo_write);
  assign status_clr = mmo_write && (mmo_address == REG_STATUS);

  mmo_wait_monitor #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .WAIT_W       (WAIT_W)
  ) u_mon (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .req      (usr_req),
    .gnt      (usr_gnt),
    .clr      (status_clr),
    .max_wait (max_wait),
    .starve   (starve)
  );

  // Status word assembly and read muxes for both ports.
  always_comb begin
    status                  = '0;
    status[WAIT_W-1:0]      = max_wait;
    status[ST_STARVE_BIT]   = starve;
    status[ST_H2F_BIT]      = h2f_irq;
    status[ST_F2H_BIT]      = f2h_irq;
    mmo_rd_val = (mmo_address == REG_STATUS) ? status : regs[mmo_address];
    usr_rd_val = (usr_addr == REG_STATUS) ? status : regs[usr_addr];
  end

  // Single write port: HPS and a granted fabric write are mutually exclusive.
  always_comb begin
    hps_wr  = mmo_write;
    fab_wr  = usr_gnt & usr_we;
    wr_addr = hps_wr ? mmo_address : usr_addr;
    wr_mask = hps_wr ? byte_mask(mmo_byteenable) : byte_mask(usr_be);
    wr_md   = (hps_wr ? mmo_writedata : usr_wdata) & wr_mask;
    wr_cur  = regs[wr_addr];
    wr_en   = (hps_wr | fab_wr) && (wr_addr != REG_STATUS);
    wr_val  = (wr_cur & ~wr_mask) | wr_md;
    if (wr_addr == REG_H2F_DB) begin
      wr_val = hps_wr ? (wr_cur | wr_md) : (wr_cur & ~wr_md);
    end else if (wr_addr == REG_F2H_DB) begin
      wr_val = fab_wr ? (wr_cur | wr_md) : (wr_cur & ~wr_md);
    end
    h2f_nxt = (wr_en && wr_addr == REG_H2F_DB) ? |wr_val : |regs[REG_H2F_DB];
    f2h_nxt = (wr_en && wr_addr == REG_F2H_DB) ? |wr_val : |regs[REG_F2H_DB];
  end

  // Register bank storage.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < (1 << ADDR_W); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_val;
    end
  end

  // Read responses and doorbell interrupts, all one cycle after the access.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mmo_readdata <= '0;
      usr_rvalid   <= 1'b0;
      usr_rdata    <= '0;
      h2f_irq      <= 1'b0;
      f2h_irq      <= 1'b0;
    end else begin
      if (mmo_read) mmo_readdata <= mmo_rd_val;
      usr_rvalid <= usr_gnt & ~usr_we;
      if (usr_gnt && !usr_we) usr_rdata <= usr_rd_val;
      h2f_irq <= h2f_nxt;
      f2h_irq <= f2h_nxt;
    end
  end

endmodule

// File: tb/tb_mmo_shared_regs_arb.sv
// tb/tb_mmo_shared_regs_arb.sv - scoreboard bench for mmo_shared_regs_arb
module tb_mmo_shared_regs_arb;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [4:0]  mmo_address = '0;
  logic [31:0] mmo_writedata = '0;
  logic [3:0]  mmo_byteenable = '0;
  logic        mmo_read = 1'b0;
  logic        mmo_write = 1'b0;
  logic [31:0] mmo_readdata;
  logic        usr_req = 1'b0;
  logic        usr_we = 1'b0;
  logic [4:0]  usr_addr = '0;
  logic [31:0] usr_wdata = '0;
  logic [3:0]  usr_be = '0;
  logic        usr_gnt;
  logic        usr_rvalid;
  logic [31:0] usr_rdata;
  logic        h2f_irq;
  logic        f2h_irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] hps_q[$];
  logic [31:0] usr_q[$];
  logic        hps_pend;

  mmo_shared_regs_arb #(.STARVE_LIMIT(64), .WAIT_W(16)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .mmo_address    (mmo_address),
    .mmo_writedata  (mmo_writedata),
    .mmo_byteenable (mmo_byteenable),
    .mmo_read       (mmo_read),
    .mmo_write      (mmo_write),
    .mmo_readdata   (mmo_readdata),
    .usr_req        (usr_req),
    .usr_we         (usr_we),
    .usr_addr       (usr_addr),
    .usr_wdata      (usr_wdata),
    .usr_be         (usr_be),
    .usr_gnt        (usr_gnt),
    .usr_rvalid     (usr_rvalid),
    .usr_rdata      (usr_rdata),
    .h2f_irq        (h2f_irq),
    .f2h_irq        (f2h_irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Track which cycles carry HPS read data (fixed latency 1).
  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) hps_pend <= 1'b0;
    else                hps_pend <= mmo_read;
  end

  // Monitor: pop expected read data whenever the DUT presents it.
  always @(negedge clk_clk) begin
    if (hps_pend) begin
      if (hps_q.size() == 0) begin
        total++; bad++;
        $display("FAIL hps_rdata: got=%h want=<none queued>", mmo_readdata);
      end else begin
        check("hps_rdata", mmo_readdata, hps_q.pop_front());
      end
    end
    if (usr_rvalid) begin
      if (usr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL usr_rvalid: got=1 want=0 (no read outstanding) rdata=%h", usr_rdata);
      end else begin
        check("usr_rdata", usr_rdata, usr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic hps_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    mmo_address = a; mmo_writedata = d; mmo_byteenable = be; mmo_write = 1'b1;
    tick();
    mmo_write = 1'b0;
  endtask

  task automatic hps_rd(input logic [4:0] a, input logic [31:0] exp);
    mmo_address = a; hps_q.push_back(exp); mmo_read = 1'b1;
    tick();
    mmo_read = 1'b0;
    tick();
  endtask

  task automatic fab(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp);
    int n;
    n = 0;
    usr_req = 1'b1; usr_we = we; usr_addr = a; usr_wdata = d; usr_be = be;
    #1;
    while (!usr_gnt && n < 200) begin
      tick(); #1; n++;
    end
    check("fab_gnt_in_budget", {31'b0, usr_gnt}, 32'd1);
    if (!we) usr_q.push_back(exp);
    tick();
    usr_req = 1'b0;
    tick();
  endtask

  // Fabric read of reg0 held off by n consecutive HPS writes to reg1.
  task automatic starve_run(input int n);
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 5'd0; usr_be = 4'hF;
    for (int i = 0; i < n; i++) begin
      mmo_address = 5'd1; mmo_writedata = i; mmo_byteenable = 4'hF; mmo_write = 1'b1;
      tick();
    end
    mmo_write = 1'b0;
    usr_q.push_back(32'h0);
    #1 check("starve_gnt_release", {31'b0, usr_gnt}, 32'd1);
    tick();
    usr_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;

    tick(); tick();
    check("rst_readdata", mmo_readdata, 32'h0);
    check("rst_gnt_rvalid_irq", {27'b0, usr_gnt, usr_rvalid, h2f_irq, f2h_irq, 1'b0}, 32'h0);
    check("rst_rdata", usr_rdata, 32'h0);
    reset_reset_n = 1'b1;
    tick();

    // Preload registers and outputs, then reset asynchronously mid-cycle.
    hps_wr(5'd5, 32'h12345678, 4'hF);
    hps_wr(5'd30, 32'h1, 4'hF);
    fab(1'b1, 5'd31, 32'h2, 4'hF, 32'h0);
    fab(1'b0, 5'd5, 32'h0, 4'hF, 32'h12345678);
    hps_rd(5'd5, 32'h12345678);
    reset_reset_n = 1'b0;
    #1;
    check("rst2_readdata", mmo_readdata, 32'h0);
    check("rst2_rdata", usr_rdata, 32'h0);
    check("rst2_irqs", {30'b0, h2f_irq, f2h_irq}, 32'h0);
    tick();
    reset_reset_n = 1'b1;
    tick();
    hps_rd(5'd5, 32'h0);

    // Byte-masked HPS write.
    hps_wr(5'd3, 32'hAABBCCDD, 4'b0101);
    hps_rd(5'd3, 32'h00BB00DD);

    // Fabric read denied for three HPS write cycles.
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 5'd3; usr_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      mmo_address = 5'd3; mmo_writedata = vals[i]; mmo_byteenable = 4'hF; mmo_write = 1'b1;
      #1 check("gnt_denied", {31'b0, usr_gnt}, 32'd0);
      tick();
    end
    mmo_write = 1'b0;
    #1 check("gnt_after_hps", {31'b0, usr_gnt}, 32'd1);
    usr_q.push_back(32'h33333333);
    tick();
    usr_req = 1'b0;
    tick();
    check("rvalid_one_cycle", {31'b0, usr_rvalid}, 32'd0);
    hps_rd(5'd29, 32'h00000003);

    // H2F doorbell: HPS sets, fabric clears.
    hps_wr(5'd30, 32'h5, 4'hF);
    check("h2f_set", {31'b0, h2f_irq}, 32'd1);
    fab(1'b1, 5'd30, 32'h1, 4'hF, 32'h0);
    check("h2f_partial", {31'b0, h2f_irq}, 32'd1);
    hps_rd(5'd30, 32'h00000004);
    fab(1'b1, 5'd30, 32'h4, 4'hF, 32'h0);
    check("h2f_clear", {31'b0, h2f_irq}, 32'd0);

    // F2H doorbell: fabric sets, HPS clears; live bit in status.
    fab(1'b1, 5'd31, 32'h80, 4'hF, 32'h0);
    check("f2h_set", {31'b0, f2h_irq}, 32'd1);
    hps_rd(5'd29, 32'h20000003);
    fab(1'b1, 5'd29, 32'hFFFFFFFF, 4'hF, 32'h0);
    hps_rd(5'd29, 32'h20000003);
    hps_wr(5'd31, 32'h80, 4'hF);
    check("f2h_clear", {31'b0, f2h_irq}, 32'd0);

    // Starvation boundary: 63 waits no flag, 64 waits sets flag.
    starve_run(63);
    hps_rd(5'd29, 32'h0000003F);
    starve_run(64);
    hps_rd(5'd29, 32'h80000040);
    hps_wr(5'd29, 32'hFFFFFFFF, 4'hF);
    hps_rd(5'd29, 32'h00000000);

    // Reset during a fabric wait.
    starve_run(2);
    hps_rd(5'd29, 32'h00000002);
    hps_wr(5'd30, 32'h1, 4'hF);
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      mmo_address = 5'd1; mmo_writedata = 32'h0; mmo_byteenable = 4'hF; mmo_write = 1'b1;
      tick();
    end
    reset_reset_n = 1'b0;
    mmo_write = 1'b0;
    usr_req = 1'b0;
    #1;
    check("rstwait_irqs", {30'b0, h2f_irq, f2h_irq}, 32'h0);
    check("rstwait_rvalid", {31'b0, usr_rvalid}, 32'd0);
    tick();
    reset_reset_n = 1'b1;
    tick();
    hps_rd(5'd29, 32'h00000000);
    hps_rd(5'd30, 32'h00000000);

    // Reset between grant and rvalid.
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 5'd3;
    #1 check("rstgnt_gnt", {31'b0, usr_gnt}, 32'd1);
    #1 reset_reset_n = 1'b0;
    usr_req = 1'b0;
    tick();
    check("rstgnt_rvalid_a", {31'b0, usr_rvalid}, 32'd0);
    reset_reset_n = 1'b1;
    tick();
    check("rstgnt_rvalid_b", {31'b0, usr_rvalid}, 32'd0);
    tick();

    check("hps_q_drained", hps_q.size(), 32'd0);
    check("usr_q_drained", usr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
